// File: rtl/dht11_pkg.sv
// Shared DHT11 protocol definitions: state encoding, default timing, frame layout, checksum.
package dht11_pkg;

    localparam int unsigned DHT11_CLK_HZ        = 100_000_000;
    localparam int unsigned DHT11_START_MIN_US  = 18000;
    localparam int unsigned DHT11_GAP_US        = 30;
    localparam int unsigned DHT11_RESP_LOW_US   = 80;
    localparam int unsigned DHT11_RESP_HIGH_US  = 80;
    localparam int unsigned DHT11_BIT_LOW_US    = 50;
    localparam int unsigned DHT11_BIT0_HIGH_US  = 28;
    localparam int unsigned DHT11_BIT1_HIGH_US  = 70;
    localparam int unsigned DHT11_FRAME_BITS    = 40;
    localparam int unsigned DHT11_US_CNT_W      = 16;
    localparam int unsigned DHT11_BIT_IDX_W     = 6;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HOST_LOW  = 4'd1,
        ST_GAP       = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_END_LOW   = 4'd7
    } dht11_state_e;

    // Frame as transmitted, MSB first starting with humidity integer byte.
    typedef struct packed {
        logic [7:0] hum_int;
        logic [7:0] hum_dec;
        logic [7:0] tmp_int;
        logic [7:0] tmp_dec;
        logic [7:0] csum;
    } dht11_frame_t;

    // Checksum is the byte sum modulo 256.
    function automatic logic [7:0] dht11_csum(input logic [7:0] hi, input logic [7:0] hd,
                                              input logic [7:0] ti, input logic [7:0] td);
        return hi + hd + ti + td;
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Restartable 1 us tick divider; clear realigns the next tick to CLK_HZ/1e6 cycles later.
module dht11_us_tick
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_HZ = DHT11_CLK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned DIV   = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_W'(DIV - 1));

    // Cycle counter within the current microsecond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dht11_sensor_responder.sv
// DHT11 sensor-side responder: detects the host start pulse and sends response plus 40-bit frame.
module dht11_sensor_responder
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DHT11_CLK_HZ,
    parameter int unsigned START_MIN_US = DHT11_START_MIN_US,
    parameter int unsigned GAP_US       = DHT11_GAP_US,
    parameter int unsigned RESP_LOW_US  = DHT11_RESP_LOW_US,
    parameter int unsigned RESP_HIGH_US = DHT11_RESP_HIGH_US,
    parameter int unsigned BIT_LOW_US   = DHT11_BIT_LOW_US,
    parameter int unsigned BIT0_HIGH_US = DHT11_BIT0_HIGH_US,
    parameter int unsigned BIT1_HIGH_US = DHT11_BIT1_HIGH_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    input  logic       csum_corrupt,
    output logic       busy,
    output logic       frame_done,
    output logic       bus_err,
    output logic [3:0] state_dbg,
    inout  wire        dhtio
);

    localparam int unsigned UW = DHT11_US_CNT_W;
    localparam int unsigned FB = DHT11_FRAME_BITS;

    dht11_state_e                state;
    logic                        drive_low;
    logic                        sync1, sync2, line_prev;
    logic [UW-1:0]               us_cnt;
    logic [1:0]                  low_us;
    logic [DHT11_BIT_IDX_W-1:0]  bit_idx;
    logic [FB-1:0]               shreg;
    dht11_frame_t                fr_c;
    logic [UW-1:0]               phase_us_c;
    logic                        timed_c, watch_c, tick_c;
    logic                        phase_end_c, contend_c, start_c, host_rise_c, restart_c;

    // Open-drain: only ever pull low or release.
    assign dhtio     = drive_low ? 1'b0 : 1'bz;
    assign state_dbg = state;

    dht11_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (restart_c),
        .tick_c (tick_c)
    );

    // Phase length and line-watch selection for the current state.
    always_comb begin
        phase_us_c = '0;
        timed_c    = 1'b0;
        watch_c    = 1'b0;
        case (state)
            ST_GAP:       begin phase_us_c = UW'(GAP_US);       timed_c = 1'b1; watch_c = 1'b1; end
            ST_RESP_LOW:  begin phase_us_c = UW'(RESP_LOW_US);  timed_c = 1'b1; end
            ST_RESP_HIGH: begin phase_us_c = UW'(RESP_HIGH_US); timed_c = 1'b1; watch_c = 1'b1; end
            ST_BIT_LOW:   begin phase_us_c = UW'(BIT_LOW_US);   timed_c = 1'b1; end
            ST_BIT_HIGH:  begin
                phase_us_c = shreg[FB-1] ? UW'(BIT1_HIGH_US) : UW'(BIT0_HIGH_US);
                timed_c    = 1'b1;
                watch_c    = 1'b1;
            end
            ST_END_LOW:   begin phase_us_c = UW'(BIT_LOW_US);   timed_c = 1'b1; end
            default:      ;
        endcase
    end

    // Transition events; any of them restarts the us time base.
    always_comb begin
        phase_end_c = timed_c && tick_c && (us_cnt == phase_us_c - 1'b1);
        contend_c   = watch_c && tick_c && !sync2 && (low_us == 2'd2);
        start_c     = (state == ST_IDLE) && enable && line_prev && !sync2;
        host_rise_c = (state == ST_HOST_LOW) && sync2;
        restart_c   = phase_end_c || contend_c || start_c || host_rise_c;
    end

    // Frame snapshot taken at start-accept.
    always_comb begin
        fr_c         = '0;
        fr_c.hum_int = hum_int;
        fr_c.hum_dec = hum_dec;
        fr_c.tmp_int = tmp_int;
        fr_c.tmp_dec = tmp_dec;
        fr_c.csum    = dht11_csum(hum_int, hum_dec, tmp_int, tmp_dec) ^ {7'd0, csum_corrupt};
    end

    // Two-flop line synchronizer plus previous value for edge detection; idle line is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= dhtio;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    // Microseconds in the current phase (saturating) and consecutive low microseconds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            us_cnt <= '0;
            low_us <= '0;
        end else begin
            if (restart_c) begin
                us_cnt <= '0;
            end else if (tick_c && (us_cnt != '1)) begin
                us_cnt <= us_cnt + 1'b1;
            end
            if (restart_c || sync2) begin
                low_us <= '0;
            end else if (tick_c && (low_us != 2'd3)) begin
                low_us <= low_us + 1'b1;
            end
        end
    end

    // Protocol sequencer with registered line drive and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            drive_low  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bus_err    <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
        end else begin
            frame_done <= 1'b0;
            bus_err    <= 1'b0;
            if (contend_c) begin
                state     <= ST_IDLE;
                drive_low <= 1'b0;
                busy      <= 1'b0;
                bus_err   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_c) state <= ST_HOST_LOW;
                    end
                    ST_HOST_LOW: begin
                        if (host_rise_c) begin
                            if (us_cnt >= UW'(START_MIN_US)) begin
                                shreg <= fr_c;
                                busy  <= 1'b1;
                                state <= ST_GAP;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (phase_end_c) begin
                            state     <= ST_RESP_LOW;
                            drive_low <= 1'b1;
                        end
                    end
                    ST_RESP_LOW: begin
                        if (phase_end_c) begin
                            state     <= ST_RESP_HIGH;
                            drive_low <= 1'b0;
                        end
                    end
                    ST_RESP_HIGH: begin
                        if (phase_end_c) begin
                            state     <= ST_BIT_LOW;
                            drive_low <= 1'b1;
                            bit_idx   <= '0;
                        end
                    end
                    ST_BIT_LOW: begin
                        if (phase_end_c) begin
                            state     <= ST_BIT_HIGH;
                            drive_low <= 1'b0;
                        end
                    end
                    ST_BIT_HIGH: begin
                        if (phase_end_c) begin
                            shreg     <= {shreg[FB-2:0], 1'b0};
                            bit_idx   <= bit_idx + 1'b1;
                            drive_low <= 1'b1;
                            state     <= (bit_idx == DHT11_BIT_IDX_W'(FB - 1)) ? ST_END_LOW : ST_BIT_LOW;
                        end
                    end
                    ST_END_LOW: begin
                        if (phase_end_c) begin
                            state      <= ST_IDLE;
                            drive_low  <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        drive_low <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dht11_sensor_responder.sv
// Directed self-checking bench for dht11_sensor_responder (2 clocks per us, short start minimum).
module tb_dht11_sensor_responder;

    localparam int CYC_PER_US = 2;
    localparam int WAIT_MAX   = 4000;
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_HOST_LOW = 4'd1;
    localparam logic [3:0] S_RESP_LOW = 4'd3;
    localparam logic [39:0] FRAME_OK  = 40'h37_00_19_05_55;
    localparam logic [39:0] FRAME_BAD = 40'h37_00_19_05_54;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
    logic       csum_corrupt;
    logic       busy, frame_done, bus_err;
    logic [3:0] state_dbg;
    logic       host_low;
    wire        dhtio;

    int checks;
    int errors;
    int fd_cnt;
    int be_cnt;
    bit timed_out;

    int          cap_gap, cap_rlo, cap_rhi, cap_end;
    int          cap_lo[40];
    int          cap_hi[40];
    logic [39:0] cap_data;
    logic        cap_busy_resp, cap_fd_end, cap_busy_end;
    logic [3:0]  cap_st_resp;

    pullup (dhtio);
    assign dhtio = host_low ? 1'b0 : 1'bz;

    dht11_sensor_responder #(
        .CLK_HZ       (2_000_000),
        .START_MIN_US (200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .hum_int      (hum_int),
        .hum_dec      (hum_dec),
        .tmp_int      (tmp_int),
        .tmp_dec      (tmp_dec),
        .csum_corrupt (csum_corrupt),
        .busy         (busy),
        .frame_done   (frame_done),
        .bus_err      (bus_err),
        .state_dbg    (state_dbg),
        .dhtio        (dhtio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (bus_err === 1'b1) be_cnt++;
    end

    // Global time limit.
    initial begin
        #(10 * 100_000);
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Count negedges until dhtio reaches lvl; -1 on timeout.
    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        if (timed_out) begin
            n = -1;
            return;
        end
        do begin
            @(negedge clk);
            n++;
        end while (dhtio !== lvl && n < WAIT_MAX);
        if (dhtio !== lvl) begin
            n = -1;
            timed_out = 1'b1;
        end
    endtask

    task automatic host_start(input int us);
        @(negedge clk);
        host_low = 1'b1;
        repeat (us * CYC_PER_US) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Record phase lengths in cycles and decode bits from the released time.
    task automatic capture_frame();
        timed_out = 1'b0;
        cap_data  = '0;
        for (int i = 0; i < 40; i++) begin
            cap_lo[i] = -1;
            cap_hi[i] = -1;
        end
        wait_level(1'b0, cap_gap);
        cap_busy_resp = busy;
        cap_st_resp   = state_dbg;
        wait_level(1'b1, cap_rlo);
        wait_level(1'b0, cap_rhi);
        for (int i = 0; i < 40; i++) begin
            wait_level(1'b1, cap_lo[i]);
            wait_level(1'b0, cap_hi[i]);
            cap_data = {cap_data[38:0], (cap_hi[i] > 98)};
        end
        wait_level(1'b1, cap_end);
        cap_fd_end   = frame_done;
        cap_busy_end = busy;
    endtask

    // Number of bit phases deviating from 100 cycles low / 56 or 140 cycles high.
    function automatic int timing_errs(input logic [39:0] exp);
        int e;
        e = 0;
        for (int i = 0; i < 40; i++) begin
            if (cap_lo[i] != 100) e++;
            if (cap_hi[i] != (exp[39 - i] ? 140 : 56)) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        host_low = 1'b0; enable = 1'b1; csum_corrupt = 1'b0;
        hum_int = 8'h37; hum_dec = 8'h00; tmp_int = 8'h19; tmp_dec = 8'h05;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dhtio !== 1'b1) begin errors++; $display("FAIL reset_line: dhtio=%b want 1", dhtio); end
        checks++; if ({busy, frame_done, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_outs: busy/fd/be=%b want 000", {busy, frame_done, bus_err}); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: state=%0d want 0", state_dbg); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_normal_frame();
        int fd0, fd_next, te;
        fd0 = fd_cnt;
        host_start(250);
        capture_frame();
        @(negedge clk);
        fd_next = frame_done;
        te = timing_errs(FRAME_OK);
        checks++; if (cap_gap != 63) begin errors++; $display("FAIL nf_gap: cycles=%0d want 63", cap_gap); end
        checks++; if (cap_busy_resp !== 1'b1) begin errors++; $display("FAIL nf_busy: busy=%b want 1", cap_busy_resp); end
        checks++; if (cap_st_resp !== S_RESP_LOW) begin errors++; $display("FAIL nf_state: state=%0d want 3", cap_st_resp); end
        checks++; if (cap_rlo != 160) begin errors++; $display("FAIL nf_resp_low: cycles=%0d want 160", cap_rlo); end
        checks++; if (cap_rhi != 160) begin errors++; $display("FAIL nf_resp_high: cycles=%0d want 160", cap_rhi); end
        checks++; if (cap_data !== FRAME_OK) begin errors++; $display("FAIL nf_data: got %h want %h", cap_data, FRAME_OK); end
        checks++; if (te != 0) begin errors++; $display("FAIL nf_bit_timing: bad phases=%0d want 0", te); end
        checks++; if (cap_end != 100) begin errors++; $display("FAIL nf_end_low: cycles=%0d want 100", cap_end); end
        checks++; if (cap_fd_end !== 1'b1 || cap_busy_end !== 1'b0) begin errors++; $display("FAIL nf_done_edge: fd=%b busy=%b want 1 0", cap_fd_end, cap_busy_end); end
        checks++; if (fd_next !== 0) begin errors++; $display("FAIL nf_done_pulse: fd next cycle=%0d want 0", fd_next); end
        checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL nf_done_count: pulses=%0d want 1", fd_cnt - fd0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_short_start();
        int act;
        logic [3:0] st_mid;
        act = 0;
        @(negedge clk);
        host_low = 1'b1;
        repeat (100) @(negedge clk);
        st_mid = state_dbg;
        repeat (100) @(negedge clk);
        host_low = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (dhtio !== 1'b1 || busy !== 1'b0) act++;
        end
        checks++; if (st_mid !== S_HOST_LOW) begin errors++; $display("FAIL ss_host_low: state=%0d want 1", st_mid); end
        checks++; if (act != 0) begin errors++; $display("FAIL ss_activity: active cycles=%0d want 0", act); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL ss_state: state=%0d want 0", state_dbg); end
    endtask

    task automatic test_csum_corrupt();
        int fd0, te;
        fd0 = fd_cnt;
        csum_corrupt = 1'b1;
        host_start(250);
        capture_frame();
        csum_corrupt = 1'b0;
        te = timing_errs(FRAME_BAD);
        checks++; if (cap_data !== FRAME_BAD) begin errors++; $display("FAIL cc_data: got %h want %h", cap_data, FRAME_BAD); end
        checks++; if (te != 0) begin errors++; $display("FAIL cc_bit_timing: bad phases=%0d want 0", te); end
        repeat (5) @(negedge clk);
        checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL cc_done_count: pulses=%0d want 1", fd_cnt - fd0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_contention();
        int n, be0, act;
        act = 0;
        timed_out = 1'b0;
        host_start(250);
        wait_level(1'b0, n);
        wait_level(1'b1, n);
        wait_level(1'b0, n);
        for (int i = 0; i < 5; i++) begin
            wait_level(1'b1, n);
            wait_level(1'b0, n);
        end
        wait_level(1'b1, n);
        checks++; if (n != 100) begin errors++; $display("FAIL ct_bit5_low: cycles=%0d want 100", n); end
        be0 = be_cnt;
        repeat (10) @(negedge clk);
        host_low = 1'b1;
        repeat (20) @(negedge clk);
        host_low = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (be_cnt - be0 != 1) begin errors++; $display("FAIL ct_bus_err: pulses=%0d want 1", be_cnt - be0); end
        checks++; if (busy !== 1'b0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL ct_idle: busy=%b state=%0d want 0 0", busy, state_dbg); end
        repeat (300) begin
            @(negedge clk);
            if (dhtio !== 1'b1) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL ct_released: low cycles=%0d want 0", act); end
    endtask

    task automatic test_reset_mid_frame();
        int n, te;
        timed_out = 1'b0;
        host_start(250);
        wait_level(1'b0, n);
        wait_level(1'b1, n);
        wait_level(1'b0, n);
        for (int i = 0; i < 20; i++) begin
            wait_level(1'b1, n);
            wait_level(1'b0, n);
        end
        repeat (10) @(negedge clk);
        checks++; if (dhtio !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rm_pre: dhtio=%b busy=%b want 0 1", dhtio, busy); end
        rst = 1'b0;
        #1;
        checks++; if (dhtio !== 1'b1) begin errors++; $display("FAIL rm_line: dhtio=%b want 1", dhtio); end
        checks++; if ({busy, frame_done, bus_err} !== 3'b000 || state_dbg !== S_IDLE) begin
            errors++; $display("FAIL rm_outs: busy/fd/be=%b state=%0d want 000 0", {busy, frame_done, bus_err}, state_dbg);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        host_start(250);
        capture_frame();
        te = timing_errs(FRAME_OK);
        checks++; if (cap_gap != 63) begin errors++; $display("FAIL rm_gap: cycles=%0d want 63", cap_gap); end
        checks++; if (cap_data !== FRAME_OK) begin errors++; $display("FAIL rm_data: got %h want %h", cap_data, FRAME_OK); end
        checks++; if (te != 0) begin errors++; $display("FAIL rm_bit_timing: bad phases=%0d want 0", te); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_mid_frame_changes();
        int act;
        act = 0;
        fork
            begin
                host_start(250);
                capture_frame();
            end
            begin
                repeat (900) @(negedge clk);
                hum_int = 8'hAA; tmp_int = 8'hBB; csum_corrupt = 1'b1; enable = 1'b0;
            end
        join
        checks++; if (cap_data !== FRAME_OK) begin errors++; $display("FAIL mc_data: got %h want %h", cap_data, FRAME_OK); end
        checks++; if (cap_fd_end !== 1'b1) begin errors++; $display("FAIL mc_done: fd=%b want 1", cap_fd_end); end
        repeat (10) @(negedge clk);
        host_start(250);
        repeat (400) begin
            @(negedge clk);
            if (dhtio !== 1'b1 || busy !== 1'b0) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL mc_disabled: active cycles=%0d want 0", act); end
        hum_int = 8'h37; tmp_int = 8'h19; csum_corrupt = 1'b0; enable = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; fd_cnt = 0; be_cnt = 0; timed_out = 1'b0;
        test_reset();
        test_normal_frame();
        test_short_start();
        test_csum_corrupt();
        test_contention();
        test_reset_mid_frame();
        test_mid_frame_changes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dht11_sensor_responder.md
Name: dht11_sensor_responder

Overview:
Synthesizable model of the DHT11 sensor end of the single-wire protocol. It is the responder to dht11_controller. It watches the shared open-drain dhtio line for the host start pulse, then drives the 80/80 us response and the 40-bit frame: humidity int/dec, temperature int/dec, checksum. It is used for loopback on the board and as the sensor stand-in for controller testbenches.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; one us = CLK_HZ/1_000_000 cycles.
START_MIN_US, 18000, minimum host low time accepted as a start request.
GAP_US, 30, wait after host release before the response low.
RESP_LOW_US, 80, response low phase.
RESP_HIGH_US, 80, response released (high) phase.
BIT_LOW_US, 50, low lead-in before every bit and after the last bit.
BIT0_HIGH_US, 28, released time encoding 0.
BIT1_HIGH_US, 70, released time encoding 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
enable  in  1  1 = respond to start requests
hum_int  in  8  humidity integer byte
hum_dec  in  8  humidity decimal byte
tmp_int  in  8  temperature integer byte
tmp_dec  in  8  temperature decimal byte
csum_corrupt  in  1  1 = transmit checksum XOR 8'h01 (error injection)
busy  out  1  high from start-accept until frame end
frame_done  out  1  one-cycle pulse when END_LOW completes
bus_err  out  1  one-cycle pulse on abort (contention)
state_dbg  out  4  current state encoding
dhtio  inout  1  open-drain line: driven 0 or released to z, never driven 1

Behaviour:
- Reset (rst=0, async): state IDLE, dhtio released (z), busy=0, frame_done=0, bus_err=0, counters cleared, shift register cleared. Reset mid-frame releases the line immediately.
- dhtio input passes through a 2-FF synchronizer; all decisions use the synchronized value (2-cycle latency).
- Time base: a us-tick divider restarts on every state transition, so each phase lasts exactly N*CLK_HZ/1e6 cycles (+2 sync cycles on host-driven edges).
- States:
  - IDLE: on falling edge of the line with enable=1 -> HOST_LOW, us counter=0.
  - HOST_LOW: count us while the line is low.
    - Line rises with count >= START_MIN_US -> latch the 4 bytes, compute csum = (sum of 4 bytes) mod 256, XOR 8'h01 if csum_corrupt; load the 40-bit shift register {hum_int,hum_dec,tmp_int,tmp_dec,csum}; go to GAP.
    - Line rises earlier -> IDLE, silently.
  - GAP: released for GAP_US -> RESP_LOW.
  - RESP_LOW: drive 0 for RESP_LOW_US -> RESP_HIGH.
  - RESP_HIGH: release for RESP_HIGH_US -> BIT_LOW, bit index=0.
  - BIT_LOW: drive 0 for BIT_LOW_US -> BIT_HIGH.
  - BIT_HIGH: release for BIT1_HIGH_US if the current MSB is 1, else BIT0_HIGH_US. Then shift left and index+1. Index 39 done -> END_LOW, else -> BIT_LOW.
  - END_LOW: drive 0 for BIT_LOW_US, then release, pulse frame_done -> IDLE.
- Bit order is MSB first, humidity integer byte first.
- busy=1 in all states from GAP through END_LOW inclusive.
- Contention: in GAP, RESP_HIGH or BIT_HIGH, the synchronized line low for more than 2 consecutive us -> release, pulse bus_err -> IDLE.
- enable deasserted mid-frame: the frame completes; only new start requests are blocked.
- Input bytes changing mid-frame have no effect; they are latched at start-accept only.
- A new host low while busy is treated as contention (above) and is not taken as a restart.

Decomposition:
- Shared package dht11_pkg: state encoding constants (IDLE..END_LOW, 4-bit), default timing constants in us, frame length 40, checksum function. dht11_controller reuses it.
- One sub-module: dht11_us_tick (restartable 1 us tick divider, CLK_HZ parameter, clear input).

Test Plan:
- Bytes 0x37,0x00,0x19,0x05, host low 18 ms then release -> line low 80 us at start+30 us, high 80 us, 40 bits decode to 0x37_00_19_05_55, frame_done pulses once, busy falls the same cycle.
- Host low 10 ms -> no line activity, busy stays 0, state returns to IDLE.
- Same bytes with csum_corrupt=1 -> transmitted checksum 0x54; all bit high times are 28 or 70 us (±0 cycles).
- Bench pulls the line low 10 us during bit 5 high phase -> bus_err pulses, line released, busy=0, state IDLE.
- rst asserted at bit 20 -> dhtio goes z within the same cycle, all outputs 0; next 18 ms start yields a full correct frame.
- Connected to dht11_controller with start pulsed -> controller reports humidity 0x37, temperature 0x19, dht11_valid=1.
